// File: rtl/spi_frame_sequencer_if.sv
// Bundles the system-side write/frame controls and the SPI-master-side byte
// handshake so the sequencer and its driver share one port list.
interface spi_frame_sequencer_if #(
    parameter int LEN_W = 8
);
    logic [7:0]       i_Wr_Byte;
    logic             i_Wr_DV;
    logic             o_Full;
    logic             o_Empty;
    logic             o_Overflow;
    logic             i_Frame_Start;
    logic [LEN_W-1:0] i_Frame_Len;
    logic             o_Busy;
    logic             o_Frame_Done;
    logic [7:0]       o_TX_Byte;
    logic             o_TX_DV;
    logic             i_TX_Ready;
    logic             o_SPI_CS_n;

    // slave: the sequencer itself
    modport slave (
        input  i_Wr_Byte, i_Wr_DV, i_Frame_Start, i_Frame_Len, i_TX_Ready,
        output o_Full, o_Empty, o_Overflow, o_Busy, o_Frame_Done,
               o_TX_Byte, o_TX_DV, o_SPI_CS_n
    );

    // master: whoever feeds bytes, starts frames and plays the SPI byte master
    modport master (
        output i_Wr_Byte, i_Wr_DV, i_Frame_Start, i_Frame_Len, i_TX_Ready,
        input  o_Full, o_Empty, o_Overflow, o_Busy, o_Frame_Done,
               o_TX_Byte, o_TX_DV, o_SPI_CS_n
    );
endinterface

// File: rtl/spi_frame_sequencer.sv
// Byte FIFO plus a CS-framing sequencer that paces TX_DV pulses into an SPI
// byte master and owns chip-select setup, hold and inter-frame gap timing.
//
//  state  | meaning
//  IDLE   | CS high, waiting for a start with nonzero length
//  SETUP  | CS low, counting setup cycles before the first byte
//  SEND   | pop FIFO head to the master when it is ready and data exists
//  DROP   | one dead cycle while the master lowers ready after DV
//  TAIL   | wait for the last byte to finish, then count CS hold
//  GAP    | CS high, counting idle cycles; Done pulses on the last one
module spi_frame_sequencer #(
    parameter int FIFO_DEPTH    = 16,
    parameter int LEN_W         = 8,
    parameter int CS_SETUP_CLKS = 4,
    parameter int CS_HOLD_CLKS  = 4,
    parameter int CS_IDLE_CLKS  = 8
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    spi_frame_sequencer_if.slave   bus
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int T_MAX = (CS_SETUP_CLKS > CS_HOLD_CLKS)
                         ? ((CS_SETUP_CLKS > CS_IDLE_CLKS) ? CS_SETUP_CLKS : CS_IDLE_CLKS)
                         : ((CS_HOLD_CLKS  > CS_IDLE_CLKS) ? CS_HOLD_CLKS  : CS_IDLE_CLKS);
    localparam int TW    = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SEND, S_DROP, S_TAIL, S_GAP
    } state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, push, pop, overflow;

    state_t           state, state_nxt;
    logic [TW-1:0]    timer, timer_nxt;
    logic [LEN_W-1:0] remain, remain_nxt;
    logic             hold_run, hold_run_nxt;
    logic             cs_n, cs_n_nxt;
    logic             done, done_nxt;
    logic             tx_dv;
    logic [7:0]       tx_byte;

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    // Full is judged on the pre-pop count, so a push in a pop cycle is still refused.
    assign push  = bus.i_Wr_DV && !full;

    always_ff @(posedge i_Clk) begin
        if (push) mem[wr_ptr] <= bus.i_Wr_Byte;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count + CW'(push) - CW'(pop);
            overflow <= bus.i_Wr_DV && full;
        end
    end

    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        remain_nxt   = remain;
        hold_run_nxt = hold_run;
        cs_n_nxt     = cs_n;
        done_nxt     = 1'b0;
        pop          = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.i_Frame_Start && bus.i_Frame_Len != '0) begin
                    state_nxt  = S_SETUP;
                    remain_nxt = bus.i_Frame_Len;
                    timer_nxt  = TW'(CS_SETUP_CLKS - 1);
                    cs_n_nxt   = 1'b0;
                end
            end
            S_SETUP: begin
                if (timer == '0) state_nxt = S_SEND;
                else             timer_nxt = timer - 1'b1;
            end
            S_SEND: begin
                if (bus.i_TX_Ready && !empty) begin
                    pop        = 1'b1;
                    remain_nxt = remain - 1'b1;
                    state_nxt  = S_DROP;
                end
            end
            S_DROP: begin
                state_nxt = (remain == '0) ? S_TAIL : S_SEND;
            end
            S_TAIL: begin
                if (!hold_run) begin
                    if (bus.i_TX_Ready) begin
                        hold_run_nxt = 1'b1;
                        timer_nxt    = TW'(CS_HOLD_CLKS - 1);
                    end
                end else if (timer == '0) begin
                    hold_run_nxt = 1'b0;
                    state_nxt    = S_GAP;
                    timer_nxt    = TW'(CS_IDLE_CLKS - 1);
                    cs_n_nxt     = 1'b1;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            S_GAP: begin
                if (timer == '0) begin
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state    <= S_IDLE;
            timer    <= '0;
            remain   <= '0;
            hold_run <= 1'b0;
            cs_n     <= 1'b1;
            done     <= 1'b0;
            tx_dv    <= 1'b0;
            tx_byte  <= '0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            remain   <= remain_nxt;
            hold_run <= hold_run_nxt;
            cs_n     <= cs_n_nxt;
            done     <= done_nxt;
            tx_dv    <= pop;
            if (pop) tx_byte <= mem[rd_ptr];
        end
    end

    assign bus.o_Full       = full;
    assign bus.o_Empty      = empty;
    assign bus.o_Overflow   = overflow;
    assign bus.o_Busy       = (state != S_IDLE);
    assign bus.o_Frame_Done = done;
    assign bus.o_TX_Byte    = tx_byte;
    assign bus.o_TX_DV      = tx_dv;
    assign bus.o_SPI_CS_n   = cs_n;
endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Bench for spi_frame_sequencer: directed frame scenarios plus randomized
// frames, all outputs compared every edge against a queue-based frame model.
module tb_spi_frame_sequencer;
    localparam int DEPTH = 16;
    localparam int LEN_W = 8;
    localparam int SETUP = 4;
    localparam int HOLD  = 4;
    localparam int IDLE  = 8;

    logic i_Clk = 1'b0;
    logic i_Rst = 1'b1;
    always #5 i_Clk = ~i_Clk;

    spi_frame_sequencer_if #(.LEN_W(LEN_W)) bus ();

    spi_frame_sequencer #(
        .FIFO_DEPTH(DEPTH), .LEN_W(LEN_W), .CS_SETUP_CLKS(SETUP),
        .CS_HOLD_CLKS(HOLD), .CS_IDLE_CLKS(IDLE)
    ) dut (
        .i_Clk(i_Clk),
        .i_Rst(i_Rst),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Frame model: FIFO contents, when the frame started, bytes sent, and the
    // CS-rise / Done edges once the last byte has completed.
    logic [7:0] byte_q[$];
    bit frm = 0;
    int s_edge, n_len, n_sent, last_dv = -100;
    int tail_from = -1, r_edge = -1, rise_edge = -1, done_edge = -1;
    int rdy_min = 1, rdy_max = 0;

    task automatic model_step();
        int sz;
        logic exp_dv, exp_cs, exp_done;
        logic [7:0] b;
        sz = byte_q.size();
        if (!frm && bus.i_Frame_Start && bus.i_Frame_Len != '0) begin
            frm = 1; s_edge = edge_n; n_len = int'(bus.i_Frame_Len); n_sent = 0;
            tail_from = -1; r_edge = -1; rise_edge = -1; done_edge = -1;
        end
        exp_dv = frm && n_sent < n_len && edge_n >= s_edge + 1 + SETUP
                 && edge_n >= last_dv + 2 && bus.i_TX_Ready && sz > 0;
        check("tx_dv", bus.o_TX_DV, exp_dv);
        if (exp_dv) begin
            b = byte_q.pop_front();
            check("tx_byte", bus.o_TX_Byte, b);
            n_sent++;
            last_dv = edge_n;
            if (n_sent == n_len) tail_from = edge_n + 2;
        end
        if (bus.i_Wr_DV && sz < DEPTH) byte_q.push_back(bus.i_Wr_Byte);
        check("overflow", bus.o_Overflow, bus.i_Wr_DV && sz == DEPTH);
        check("empty", bus.o_Empty, byte_q.size() == 0);
        check("full", bus.o_Full, byte_q.size() == DEPTH);
        if (frm && tail_from >= 0 && r_edge < 0 && edge_n >= tail_from && bus.i_TX_Ready) begin
            r_edge = edge_n;
            rise_edge = r_edge + HOLD;
            done_edge = rise_edge + IDLE;
        end
        exp_cs = !(frm && !(rise_edge >= 0 && edge_n >= rise_edge));
        check("cs_n", bus.o_SPI_CS_n, exp_cs);
        exp_done = frm && edge_n == done_edge;
        check("frame_done", bus.o_Frame_Done, exp_done);
        if (exp_done) frm = 0;
        check("busy", bus.o_Busy, frm);
    endtask

    always begin
        @(posedge i_Clk);
        #1;
        edge_n++;
        if (i_Rst) begin
            byte_q.delete();
            frm = 0; last_dv = -100; tail_from = -1;
            check("rst_cs_n", bus.o_SPI_CS_n, 1);
            check("rst_dv", bus.o_TX_DV, 0);
            check("rst_empty", bus.o_Empty, 1);
            check("rst_full", bus.o_Full, 0);
            check("rst_ovf", bus.o_Overflow, 0);
            check("rst_busy", bus.o_Busy, 0);
            check("rst_done", bus.o_Frame_Done, 0);
            check("rst_byte", bus.o_TX_Byte, 0);
        end else begin
            model_step();
        end
    end

    // SPI byte master: drops ready for a few cycles after each DV.
    initial begin
        bus.i_TX_Ready = 1'b1;
        forever begin
            @(negedge i_Clk);
            if (bus.o_TX_DV && rdy_max > 0) begin
                bus.i_TX_Ready = 1'b0;
                repeat ($urandom_range(rdy_max, rdy_min)) @(negedge i_Clk);
                bus.i_TX_Ready = 1'b1;
            end
        end
    end

    task automatic drive(input logic wr, input logic [7:0] b, input logic st,
                         input logic [LEN_W-1:0] len);
        bus.i_Wr_DV = wr; bus.i_Wr_Byte = b;
        bus.i_Frame_Start = st; bus.i_Frame_Len = len;
        @(negedge i_Clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 8'h00, 0, '0);
    endtask

    task automatic push(input logic [7:0] b);
        drive(1, b, 0, '0);
    endtask

    task automatic start(input int len);
        drive(0, 8'h00, 1, LEN_W'(len));
    endtask

    task automatic wait_frame(input int bound);
        int k = 0;
        while (frm && k < bound) begin
            idle(1);
            k++;
        end
        check("frame_timeout", frm, 0);
        idle(2);
    endtask

    task automatic do_reset();
        i_Rst = 1'b1;
        idle(2);
        i_Rst = 1'b0;
        idle(1);
    endtask

    initial begin
        int k, len;
        logic [7:0] t1[3];
        t1[0] = 8'hA5; t1[1] = 8'h3C; t1[2] = 8'h0F;
        bus.i_Wr_DV = 0; bus.i_Wr_Byte = 0; bus.i_Frame_Start = 0; bus.i_Frame_Len = 0;
        @(negedge i_Clk);
        do_reset();

        // three bytes, slow master
        rdy_min = 34; rdy_max = 34;
        for (int i = 0; i < 3; i++) push(t1[i]);
        start(3);
        wait_frame(400);

        // frame started on an empty FIFO stalls until data arrives
        rdy_min = 1; rdy_max = 3;
        start(2);
        idle(20);
        push(8'h11);
        idle(30);
        push(8'h22);
        wait_frame(400);

        // overfill, then a frame takes only what was kept
        for (int i = 0; i < DEPTH + 1; i++) push(8'(8'h40 + i));
        idle(2);
        start(DEPTH);
        wait_frame(800);

        // zero length ignored; start during a frame ignored
        start(0);
        idle(20);
        for (int i = 0; i < 3; i++) push(8'(8'h70 + i));
        start(3);
        idle(8);
        start(5);
        wait_frame(400);

        // reset in the DROP cycle of byte 2 of 4, then a clean frame
        for (int i = 0; i < 4; i++) push(8'(8'h80 + i));
        start(4);
        k = 0;
        while (n_sent < 2 && k < 300) begin
            idle(1);
            k++;
        end
        check("t5_reach_byte2", n_sent, 2);
        i_Rst = 1'b1;
        idle(1);
        i_Rst = 1'b0;
        idle(3);
        push(8'h91); push(8'h92);
        start(2);
        wait_frame(400);

        // always-ready master, full FIFO, pushes hammering during pops
        rdy_max = 0;
        for (int i = 0; i < DEPTH; i++) push(8'($urandom));
        start(DEPTH);
        for (int i = 0; i < 60; i++) drive(1, 8'($urandom), 0, '0);
        wait_frame(400);
        rdy_min = 1; rdy_max = 4;
        if (byte_q.size() > 0) start(byte_q.size());
        wait_frame(800);

        // randomized frames, pushes before or during the frame
        for (int it = 0; it < 20; it++) begin
            len = $urandom_range(12, 1);
            rdy_max = $urandom_range(6, 0);
            k = len + $urandom_range(2, 0);
            if ($urandom_range(1, 0) == 1) begin
                for (int i = 0; i < k; i++) push(8'($urandom));
                start(len);
            end else begin
                start(len);
                for (int i = 0; i < k; i++) begin
                    idle($urandom_range(3, 0));
                    push(8'($urandom));
                end
            end
            wait_frame(1500);
            idle($urandom_range(4, 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
